regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and writeback arbiter state encoding.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter: port A has priority, port B is
// forced through after STARVE_LIMIT consecutive lost cycles.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [REG_DATA_W-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [REG_DATA_W-1:0] b_data,
  output logic                  b_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [REG_DATA_W-1:0] rf_wd,
  output logic                  b_forced
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  a_xfer, b_xfer, xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_DATA_W-1:0] sel_data;

  // Readies depend only on state and the opposite port's valid.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    b_forced = 1'b0;
    if (!rst) begin
      if (state == PRIO_A) begin
        a_ready = 1'b1;
        b_ready = !a_valid;
      end else begin
        b_ready  = 1'b1;
        a_ready  = !b_valid;
        b_forced = 1'b1;
      end
    end
  end

  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign xfer     = a_xfer || b_xfer;
  assign sel_addr = a_xfer ? a_addr : b_addr;
  assign sel_data = a_xfer ? a_data : b_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!b_valid || b_xfer) cnt_nxt = '0;
    else                    cnt_nxt = cnt + 4'd1;
    case (state)
      PRIO_A: begin
        if (b_valid && !b_xfer && cnt == LIMIT_M1) begin
          state_nxt = FORCE_B;
          cnt_nxt   = '0;
        end
      end
      FORCE_B: begin
        if (b_xfer || !b_valid) state_nxt = PRIO_A;
      end
    endcase
  end

  // Output register stage: one write per transfer, r0 writes suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIO_A;
      cnt   <= '0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rf_we <= xfer && (sel_addr != '0);
      if (xfer) begin
        rf_wa <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue of expected write-port values.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        b_forced;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] shadow [32];
  logic [4:0]  hold_wa;
  logic [31:0] hold_wd;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .b_forced(b_forced)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the expected write is queued before the edge and popped after it.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ear, input logic ebr, input logic efor, input string tag);
    wr_t e, got;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    if (r) begin
      e = '0; hold_wa = '0; hold_wd = '0;
    end else if (av && ear) begin
      e.we = (aa != 5'd0); e.wa = aa; e.wd = ad; hold_wa = aa; hold_wd = ad;
    end else if (bv && ebr) begin
      e.we = (ba != 5'd0); e.wa = ba; e.wd = bd; hold_wa = ba; hold_wd = bd;
    end else begin
      e.we = 1'b0; e.wa = hold_wa; e.wd = hold_wd;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, got.we});
    chk({tag, ".rf_wa"}, {27'd0, rf_wa}, {27'd0, got.wa});
    chk({tag, ".rf_wd"}, rf_wd, got.wd);
    chk({tag, ".b_forced"}, {31'd0, b_forced}, {31'd0, efor});
    if (rf_we === 1'b1) shadow[rf_wa] = rf_wd;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, tag);
  endtask

  initial begin
    int m;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    hold_wa = '0; hold_wd = '0;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

    // Reset held 3 cycles with both ports requesting; requests are discarded.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, 1'b0, 1'b0, 1'b0, "rst");
    idle("post_rst");
    idle("post_rst2");

    // Port A alone.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "a_only");
    idle("a_only_after");

    // Port B write to r0: handshake completes, no write enable.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0, "b_r0");
    idle("b_r0_after");

    // Continuous contention: A wins 4, B forced on the 5th, repeating.
    for (int k = 0; k < 10; k++) begin
      m = k % 5;
      step(1'b0, 1'b1, 5'd1, 32'h100 + k, 1'b1, 5'd2, 32'h200 + k,
           (m != 4), (m == 4), (m == 3), $sformatf("starve%0d", k));
    end
    idle("starve_after");

    // Same destination from both ports: grant order is register-file order.
    step(1'b0, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b1, 1'b0, 1'b0, "same_a");
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2, 1'b1, 1'b1, 1'b0, "same_b");
    idle("same_after");
    chk("same_final_r7", shadow[7], 32'd2);
    chk("a_only_r5", shadow[5], 32'hDEADBEEF);

    // Reset while forcing B: no B write, state and counter return to their reset values.
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, 5'd9, 32'h900 + k, 1'b1, 5'd10, 32'hA00 + k,
           1'b1, 1'b0, (k == 3), $sformatf("pre_rst%0d", k));
    step(1'b1, 1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b0, 1'b0, 1'b0, "rst_forced");
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b1, 5'd11, 32'hB00 + k, 1'b1, 5'd12, 32'hC00 + k,
           (k != 4), (k == 4), (k == 3), $sformatf("post_force%0d", k));
    idle("final_idle");
    chk("no_b_r10_write", shadow[10], 32'd0);
    chk("b_r12_forced", shadow[12], 32'hC04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
